// File: rtl/kalman_mc_fx.sv
// Multi-channel fixed-point scalar Kalman filter: one time-shared datapath
// (load, predict, restoring divide, update) serving CH_NUM independent X/P states.

module kalman_mc_ch #(
  parameter int XW     = 17,
  parameter int P_W    = 24,
  parameter int P_INIT = 256
)(
  input  logic           clk_50M,
  input  logic           Rst,
  input  logic           clr,
  input  logic           wr,
  input  logic [XW-1:0]  wr_x,
  input  logic [P_W-1:0] wr_p,
  output logic [XW-1:0]  x,
  output logic [P_W-1:0] p
);
  // A clear on the same edge as a writeback wins.
  always_ff @(posedge clk_50M or posedge Rst) begin
    if (Rst) begin
      x <= '0;
      p <= P_W'(P_INIT);
    end else if (clr) begin
      x <= '0;
      p <= P_W'(P_INIT);
    end else if (wr) begin
      x <= wr_x;
      p <= wr_p;
    end
  end
endmodule

module kalman_mc_fx #(
  parameter int DATA_W = 9,
  parameter int FRAC_W = 8,
  parameter int CH_NUM = 4,
  parameter int P_W    = 24,
  parameter int P_INIT = 256,
  parameter int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
)(
  input  logic                     clk_50M,
  input  logic                     Rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [CH_W-1:0]          i_ch,
  input  logic [DATA_W-1:0]        i_data,
  input  logic [P_W-1:0]           i_q_err,
  input  logic [P_W-1:0]           i_r_err,
  input  logic                     i_clr,
  input  logic [CH_W-1:0]          i_clr_ch,
  output logic                     o_valid,
  output logic [CH_W-1:0]          o_ch,
  output logic [DATA_W-1:0]        o_x,
  output logic [DATA_W+FRAC_W-1:0] o_x_full,
  output logic [FRAC_W:0]          o_kg,
  output logic [P_W-1:0]           o_p
);
  localparam int XW = DATA_W + FRAC_W;
  localparam int KW = FRAC_W + 1;
  localparam int DW = P_W + 1;
  localparam int RW = P_W + 2;
  localparam int SW = XW + KW + 3;
  localparam int CW = $clog2(KW);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PRED, S_DIV, S_UPD, S_OUT} state_t;

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] z;
    logic [P_W-1:0]    q;
    logic [P_W-1:0]    r;
  } req_t;

  state_t                  state;
  req_t                    req;
  logic [CH_W-1:0]         in_ch, clr_ch;
  logic [XW-1:0]           x_r;
  logic [P_W-1:0]          p_r, p_pred;
  logic [DW-1:0]           d_r;
  logic [RW-1:0]           rem;
  logic [KW-1:0]           quo, kg_r;
  logic [CW-1:0]           cnt;
  logic                    kg_one, upd_ph, clr_hit;
  logic signed [SW-1:0]    prod_x;
  logic [P_W+KW-1:0]       prod_p;

  logic [CH_NUM-1:0][XW-1:0]  ch_x;
  logic [CH_NUM-1:0][P_W-1:0] ch_p;

  // Out-of-range channel numbers fold onto the last channel.
  generate
    if ((1 << CH_W) > CH_NUM) begin : g_clamp
      assign in_ch  = (i_ch > CH_W'(CH_NUM-1)) ? CH_W'(CH_NUM-1) : i_ch;
      assign clr_ch = (i_clr_ch > CH_W'(CH_NUM-1)) ? CH_W'(CH_NUM-1) : i_clr_ch;
    end else begin : g_noclamp
      assign in_ch  = i_ch;
      assign clr_ch = i_clr_ch;
    end
  endgenerate

  generate
    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      kalman_mc_ch #(.XW(XW), .P_W(P_W), .P_INIT(P_INIT)) u_ch (
        .clk_50M (clk_50M),
        .Rst     (Rst),
        .clr     (i_clr && (clr_ch == CH_W'(c))),
        .wr      ((state == S_OUT) && !clr_hit && (req.ch == CH_W'(c))),
        .wr_x    (o_x_full),
        .wr_p    (o_p),
        .x       (ch_x[c]),
        .p       (ch_p[c])
      );
    end
  endgenerate

  logic [P_W:0]          p_sum;
  logic [P_W-1:0]        p_pred_c;
  logic [DW-1:0]         d_c;
  logic                  rem_ge;
  logic [RW-1:0]         rem_nx, rem_sh;
  logic [KW-1:0]         kg_c;
  logic signed [XW+1:0]  diff;
  logic signed [SW-1:0]  kg_s, diff_s, prod_x_c, x_sum;
  logic [P_W+KW-1:0]     prod_p_c;
  logic [XW-1:0]         x_new;
  logic [XW:0]           x_rnd;
  logic [DATA_W:0]       x_int;
  logic [DATA_W-1:0]     x_out;
  logic                  unused_bits;

  always_comb begin
    p_sum    = {1'b0, p_r} + {1'b0, req.q};
    p_pred_c = p_sum[P_W] ? {P_W{1'b1}} : p_sum[P_W-1:0];
    d_c      = {1'b0, p_pred_c} + {1'b0, req.r};

    rem_ge = rem >= {1'b0, d_r};
    rem_nx = rem_ge ? rem - {1'b0, d_r} : rem;
    rem_sh = {rem_nx[RW-2:0], 1'b0};

    kg_c     = kg_one ? KW'(1 << FRAC_W) : quo;
    diff     = $signed({2'b0, req.z, {FRAC_W{1'b0}}}) - $signed({2'b0, x_r});
    kg_s     = SW'($signed({1'b0, kg_c}));
    diff_s   = SW'(diff);
    prod_x_c = kg_s * diff_s;
    prod_p_c = (P_W+KW)'(KW'(1 << FRAC_W) - kg_c) * (P_W+KW)'(p_pred);

    // Floor shift of the correction, then clamp to the unsigned X range.
    x_sum = $signed({{(SW-XW){1'b0}}, x_r}) + (prod_x >>> FRAC_W);
    if (x_sum[SW-1])
      x_new = '0;
    else if (|x_sum[SW-2:XW])
      x_new = {XW{1'b1}};
    else
      x_new = x_sum[XW-1:0];

    x_rnd = {1'b0, x_new} + (XW+1)'(1 << (FRAC_W-1));
    x_int = x_rnd[XW:FRAC_W];
    x_out = x_int[DATA_W] ? {DATA_W{1'b1}} : x_int[DATA_W-1:0];

    unused_bits = ^{rem_nx[RW-1], x_rnd[FRAC_W-1:0],
                    prod_p[FRAC_W-1:0], prod_p[P_W+KW-1:P_W+FRAC_W]};
  end

  always_ff @(posedge clk_50M or posedge Rst) begin
    if (Rst) begin
      state    <= S_IDLE;
      req      <= '0;
      i_ready  <= 1'b1;
      x_r      <= '0;
      p_r      <= '0;
      p_pred   <= '0;
      d_r      <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      kg_one   <= 1'b0;
      upd_ph   <= 1'b0;
      kg_r     <= '0;
      prod_x   <= '0;
      prod_p   <= '0;
      clr_hit  <= 1'b0;
      o_valid  <= 1'b0;
      o_ch     <= '0;
      o_x      <= '0;
      o_x_full <= '0;
      o_kg     <= '0;
      o_p      <= '0;
    end else begin
      o_valid <= 1'b0;
      // A clear of the in-flight channel cancels this sample's writeback.
      if (state != S_IDLE && i_clr && clr_ch == req.ch)
        clr_hit <= 1'b1;
      case (state)
        S_IDLE: if (i_valid) begin
          req.ch  <= in_ch;
          req.z   <= i_data;
          req.q   <= i_q_err;
          req.r   <= i_r_err;
          clr_hit <= 1'b0;
          i_ready <= 1'b0;
          state   <= S_LOAD;
        end
        S_LOAD: begin
          x_r   <= ch_x[req.ch];
          p_r   <= ch_p[req.ch];
          state <= S_PRED;
        end
        S_PRED: begin
          p_pred <= p_pred_c;
          d_r    <= d_c;
          rem    <= {2'b0, p_pred_c};
          quo    <= '0;
          cnt    <= '0;
          kg_one <= (d_c == '0) || (req.r == '0);
          state  <= S_DIV;
        end
        S_DIV: begin
          rem <= rem_sh;
          quo <= {quo[KW-2:0], rem_ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(KW-1)) begin
            upd_ph <= 1'b0;
            state  <= S_UPD;
          end
        end
        S_UPD: if (!upd_ph) begin
          prod_x <= prod_x_c;
          prod_p <= prod_p_c;
          kg_r   <= kg_c;
          upd_ph <= 1'b1;
        end else begin
          o_valid  <= 1'b1;
          o_ch     <= req.ch;
          o_x      <= x_out;
          o_x_full <= x_new;
          o_kg     <= kg_r;
          o_p      <= prod_p[FRAC_W +: P_W];
          state    <= S_OUT;
        end
        S_OUT: begin
          i_ready <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kalman_mc_fx.sv
// Directed bench for kalman_mc_fx: hand-computed vectors plus a per-channel reference model.

module tb_kalman_mc_fx;
  localparam int DATA_W = 9;
  localparam int FRAC_W = 8;
  localparam int CH_NUM = 4;
  localparam int P_W    = 24;
  localparam int CH_W   = 2;

  logic                     clk_50M = 1'b0;
  logic                     Rst = 1'b1;
  logic                     i_valid = 1'b0;
  logic                     i_ready;
  logic [CH_W-1:0]          i_ch = '0;
  logic [DATA_W-1:0]        i_data = '0;
  logic [P_W-1:0]           i_q_err = '0;
  logic [P_W-1:0]           i_r_err = '0;
  logic                     i_clr = 1'b0;
  logic [CH_W-1:0]          i_clr_ch = '0;
  logic                     o_valid;
  logic [CH_W-1:0]          o_ch;
  logic [DATA_W-1:0]        o_x;
  logic [DATA_W+FRAC_W-1:0] o_x_full;
  logic [FRAC_W:0]          o_kg;
  logic [P_W-1:0]           o_p;

  int checks = 0;
  int errors = 0;
  longint mx [CH_NUM];
  longint mp [CH_NUM];

  always #10 clk_50M = ~clk_50M;

  kalman_mc_fx #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .CH_NUM(CH_NUM), .P_W(P_W), .P_INIT(256)) dut (
    .clk_50M(clk_50M), .Rst(Rst), .i_valid(i_valid), .i_ready(i_ready), .i_ch(i_ch),
    .i_data(i_data), .i_q_err(i_q_err), .i_r_err(i_r_err), .i_clr(i_clr), .i_clr_ch(i_clr_ch),
    .o_valid(o_valid), .o_ch(o_ch), .o_x(o_x), .o_x_full(o_x_full), .o_kg(o_kg), .o_p(o_p)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void golden(input longint x, input longint p, input longint z,
                                 input longint q, input longint r,
                                 output longint kg, output longint xn, output longint pn);
    longint pp, d, t;
    pp = p + q;
    if (pp > 64'hFFFFFF) pp = 64'hFFFFFF;
    d  = pp + r;
    kg = (d == 0 || r == 0) ? 256 : (pp * 256) / d;
    t  = kg * (z * 256 - x);
    xn = x + (t >>> 8);
    if (xn < 0) xn = 0;
    if (xn > 131071) xn = 131071;
    pn = ((256 - kg) * pp) >> 8;
  endfunction

  task automatic accept(input int ch, input int z, input int q, input int r,
                        input bit clr, input bit hold);
    int n;
    n = 0;
    @(negedge clk_50M);
    while (!i_ready && n < 60) begin
      @(negedge clk_50M);
      n++;
    end
    chk("ready_before_accept", i_ready, 1);
    i_ch = CH_W'(ch); i_data = DATA_W'(z); i_q_err = P_W'(q); i_r_err = P_W'(r);
    i_clr = clr; i_clr_ch = CH_W'(ch);
    i_valid = 1'b1;
    @(posedge clk_50M);
    #1;
    i_valid = hold;
    i_clr = 1'b0;
  endtask

  // Waits for o_valid; optionally pulses a clear of clr_ch after edge clr_at.
  task automatic wait_out(input int clr_at, input int clr_ch);
    int lat;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk_50M);
      #1;
      if (i_clr) i_clr = 1'b0;
      if (n == clr_at) begin
        i_clr = 1'b1;
        i_clr_ch = CH_W'(clr_ch);
      end
      if (o_valid) begin
        lat = n;
        break;
      end
    end
    i_clr = 1'b0;
    chk("latency", lat, 13);
  endtask

  task automatic send(input int ch, input int z, input int q, input int r);
    accept(ch, z, q, r, 1'b0, 1'b0);
    wait_out(-1, 0);
  endtask

  task automatic chk_out(input string tag, input longint kg, input longint xf, input longint p);
    chk({tag, "_kg"}, o_kg, kg);
    chk({tag, "_xfull"}, o_x_full, xf);
    chk({tag, "_x"}, o_x, (xf + 128) >> 8);
    chk({tag, "_p"}, o_p, p);
  endtask

  initial begin
    longint kg, xn, pn;
    int vcnt;

    // Reset state
    repeat (3) @(posedge clk_50M);
    #1;
    chk("rst_ready", i_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_x", o_x, 0);
    chk("rst_xfull", o_x_full, 0);
    chk("rst_kg", o_kg, 0);
    chk("rst_p", o_p, 0);
    chk("rst_ch", o_ch, 0);
    @(negedge clk_50M);
    Rst = 1'b0;

    // First sample on ch0
    accept(0, 100, 256, 768, 1'b0, 1'b0);
    chk("busy_ready", i_ready, 0);
    wait_out(-1, 0);
    chk_out("t1", 102, 10200, 308);
    chk("t1_ch", o_ch, 0);
    @(posedge clk_50M);
    #1;
    chk("t1_vld_pulse", o_valid, 0);
    chk("t1_ready_back", i_ready, 1);
    chk("t1_hold_x", o_x, 40);
    mx[0] = 10200; mp[0] = 308;

    // R=0 forces unity gain
    send(1, 100, 256, 0);
    chk_out("t2", 256, 25600, 0);
    chk("t2_ch", o_ch, 1);

    // Interleaved channels against independent models
    mx[2] = 0; mp[2] = 256;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        int c, z;
        c = (k == 0) ? 0 : 2;
        z = (k == 0) ? 100 : 200;
        golden(mx[c], mp[c], z, 256, 768, kg, xn, pn);
        send(c, z, 256, 768);
        chk_out($sformatf("xt_c%0d_s%0d", c, i), kg, xn, pn);
        chk($sformatf("xt_c%0d_s%0d_ch", c, i), o_ch, c);
        mx[c] = xn; mp[c] = pn;
      end
    end

    // Measurement below the estimate (negative innovation)
    golden(mx[0], mp[0], 20, 256, 768, kg, xn, pn);
    send(0, 20, 256, 768);
    chk_out("neg", kg, xn, pn);
    mx[0] = xn; mp[0] = pn;

    // P_ saturation on fresh ch3
    send(3, 100, 24'hFFFFFF, 768);
    chk_out("psat", 255, 25500, 65535);

    // Full-scale measurement repeated
    for (int i = 0; i < 64; i++) send(3, 511, 0, 0);
    chk("fs_x", o_x, 511);
    chk("fs_xfull", o_x_full, 130816);
    chk("fs_kg", o_kg, 256);
    chk("fs_p", o_p, 0);

    // Clear of the in-flight channel during DIV
    golden(mx[0], mp[0], 100, 256, 768, kg, xn, pn);
    accept(0, 100, 256, 768, 1'b0, 1'b0);
    wait_out(4, 0);
    chk_out("clr_inflight", kg, xn, pn);
    send(0, 100, 256, 768);
    chk_out("clr_after", 102, 10200, 308);

    // Clear coinciding with accept on ch2
    accept(2, 100, 256, 768, 1'b1, 1'b0);
    wait_out(-1, 0);
    chk_out("clr_accept", 102, 10200, 308);

    // Reset during DIV
    accept(1, 100, 256, 768, 1'b0, 1'b0);
    repeat (4) @(posedge clk_50M);
    #1;
    Rst = 1'b1;
    @(posedge clk_50M);
    #1;
    Rst = 1'b0;
    vcnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk_50M);
      #1;
      if (o_valid) vcnt++;
    end
    chk("rst_mid_no_valid", vcnt, 0);
    chk("rst_mid_ready", i_ready, 1);
    send(1, 100, 256, 768);
    chk_out("rst_mid_next", 102, 10200, 308);

    // i_valid held while busy
    accept(0, 100, 256, 768, 1'b0, 1'b1);
    vcnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk_50M);
      #1;
      if (n == 10) i_valid = 1'b0;
      if (o_valid) vcnt++;
    end
    chk("hold_one_result", vcnt, 1);
    chk("hold_ready", i_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kalman_mc_fx.md
Name: kalman_mc_fx

Overview:
Multi-channel, fixed-point scalar Kalman filter for smoothing per-channel measurement streams in the video datapath, such as per-zone brightness statistics. It replaces the single-channel floating-point top with a parametrised design. Up to CH_NUM channels share one time-multiplexed datapath, each with its own X/P state. Q and R are runtime inputs, and any channel can be cleared individually.

Parameters:
DATA_W, 9, measurement width (unsigned integer)
FRAC_W, 8, fraction bits of X, P, Kg
CH_NUM, 4, number of channels (≥1); CH_W = max(1, clog2(CH_NUM))
P_W, 24, width of P/Q/R (unsigned, Q(P_W-FRAC_W).FRAC_W)
P_INIT, 256, P value loaded at reset/clear (1.0)

Ports:
clk_50M  in  1  clock
Rst  in  1  asynchronous active-high reset
i_valid  in  1  measurement valid
i_ready  out  1  block can accept a measurement
i_ch  in  CH_W  channel of measurement
i_data  in  DATA_W  measurement z (integer)
i_q_err  in  P_W  process noise Q (sampled at accept)
i_r_err  in  P_W  measurement noise R (sampled at accept)
i_clr  in  1  clear-channel strobe
i_clr_ch  in  CH_W  channel to clear
o_valid  out  1  one-cycle result strobe (no backpressure)
o_ch  out  CH_W  channel of result
o_x  out  DATA_W  X rounded to integer: (X + 2^(FRAC_W-1)) >> FRAC_W, saturated to 2^DATA_W-1
o_x_full  out  DATA_W+FRAC_W  X full precision
o_kg  out  FRAC_W+1  gain Kg, Q1.FRAC_W
o_p  out  P_W  updated P

Behaviour:
- Reset: all outputs 0 except i_ready=1. Every channel set to X=0, P=P_INIT. FSM goes to IDLE. Any in-flight sample is discarded with no o_valid.
- Accept: i_valid & i_ready on a clock edge (cycle 0). i_data, i_ch, i_q_err and i_r_err are captured. i_ready=1 only in IDLE.
- FSM: IDLE -> LOAD -> PRED -> DIV (exactly FRAC_W+1 cycles) -> UPD -> OUT -> IDLE.
- o_valid rises on the edge FRAC_W+5 cycles after the accept edge. It is high for one cycle in OUT; i_ready returns high the cycle after.
- LOAD: read X, P of the channel.
- PRED: X_ = X. P_ = P + Q, saturating at 2^P_W-1. Denominator D = P_ + R, P_W+1 bits.
- DIV: restoring divider computes Kg = floor(P_ * 2^FRAC_W / D). If D==0 or R==0, Kg = 2^FRAC_W (1.0).
- UPD:
  - diff = z*2^FRAC_W - X_, signed.
  - X = X_ + ((Kg*diff) >>> FRAC_W), arithmetic shift (floor). Clamp to [0, 2^(DATA_W+FRAC_W)-1].
  - P = ((2^FRAC_W - Kg) * P_) >> FRAC_W.
- OUT: write X, P back to the channel and present outputs. Outputs hold their values until the next OUT.
- i_ch ≥ CH_NUM: the sample is accepted and processed as channel CH_NUM-1 (clamped).
- i_clr: the channel is reset to X=0, P=P_INIT on the next edge, in any state.
  - Clear of the in-flight channel: the writeback is suppressed and the clear wins. o_valid still fires with the computed values.
  - Clear coinciding with accept on the same channel: the clear is applied first and LOAD reads the cleared state.
- i_valid while busy is ignored. The source must hold it until i_ready.

Test Plan:
- Reset, ch0, Q=256, R=768, z=100 -> o_valid at cycle 13 after accept; o_kg=102, o_x_full=10200, o_x=40, o_p=308.
- R=0, Q=256, z=100 on fresh ch1 -> o_kg=256, o_x_full=25600, o_x=100, o_p=0.
- Alternate ch0/ch2 with z=100 and z=200, R=768, four samples each -> each channel's X/P sequence matches an independent single-channel golden model; no cross-talk.
- z=511 repeated 64 times, Q=0, R=0 -> o_x=511, o_x_full=130816, no overflow. P_ saturation: Q=2^24-1 -> P_ clamps, Kg ≤256.
- i_clr on ch0 during DIV of a ch0 sample -> o_valid fires; next ch0 sample with z=100, Q=256, R=768 gives o_kg=102, o_x=40 (cleared state).
- Assert Rst during DIV -> no o_valid, i_ready=1 after release; next sample behaves as from reset. i_valid held while busy -> accepted only once.
